// File: rtl/rp_acq_ctrl.sv
// rp_acq_ctrl: acquisition sequencer for one ADC channel.
// Picks the alignment tap per trigger class and drives the capture buffer.
module rp_acq_ctrl #(
  parameter int CW = 32,
  parameter int AW = 14,
  parameter int TW = 2
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          cfg_arm_i,
  input  logic          cfg_abort_i,
  input  logic [3:0]    cfg_trg_src_i,
  input  logic          cfg_trg_new_i,
  input  logic [CW-1:0] cfg_pre_i,
  input  logic [CW-1:0] cfg_post_i,
  input  logic          dat_val_i,
  input  logic          trg_i,
  output logic [TW-1:0] dly_sel_o,
  output logic          acq_wr_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] trg_ptr_o,
  output logic          trg_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] pre_cnt;
  logic [CW-1:0] post_cnt;
  logic [AW-1:0] addr;
  logic [TW-1:0] pend_tap;
  logic [TW-1:0] map_tap;
  logic          map_hit;
  logic          lvl_src;
  logic          ext_src;
  logic          idle_like;
  logic          arm_ok;
  logic          wr_en;
  logic          fire;
  logic          pre_last;
  logic          post_last;

  assign lvl_src = (cfg_trg_src_i >= 4'd2 && cfg_trg_src_i <= 4'd5) ||
                   (cfg_trg_src_i >= 4'd10 && cfg_trg_src_i <= 4'd13);
  assign ext_src = cfg_trg_src_i >= 4'd6 && cfg_trg_src_i <= 4'd9;

  always_comb begin
    map_hit = 1'b0;
    map_tap = '0;
    unique case (1'b1)
      lvl_src: begin
        map_hit = 1'b1;
        map_tap = TW'(1);
      end
      ext_src: begin
        map_hit = 1'b1;
        map_tap = TW'(2);
      end
      default: ;
    endcase
  end

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign arm_ok    = cfg_arm_i && !cfg_abort_i && idle_like;
  assign wr_en     = busy_o && dat_val_i && !cfg_abort_i;
  assign fire      = (state == S_WAIT) && trg_i && dat_val_i
                     && !cfg_abort_i;
  assign pre_last  = pre_cnt == cfg_pre_i - CW'(1);
  assign post_last = post_cnt == cfg_post_i - CW'(1);

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) state <= S_IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (cfg_abort_i) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE:
          if (cfg_arm_i) nxt = (cfg_pre_i == '0) ? S_WAIT : S_PRE;
        S_PRE:
          if (dat_val_i && pre_last) nxt = S_WAIT;
        S_WAIT:
          if (trg_i && dat_val_i)
            nxt = (cfg_post_i == '0) ? S_DONE : S_POST;
        S_POST:
          if (dat_val_i && post_last) nxt = S_DONE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    done_o  = state == S_DONE;
    state_o = state;
  end

  // Tap only moves while the capture is not running.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      pend_tap  <= '0;
      dly_sel_o <= '0;
    end else begin
      if (cfg_trg_new_i && map_hit) pend_tap <= map_tap;
      if (idle_like)
        dly_sel_o <= (arm_ok && cfg_trg_new_i && map_hit) ?
                     map_tap : pend_tap;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      pre_cnt   <= '0;
      post_cnt  <= '0;
      addr      <= '0;
      wr_ptr_o  <= '0;
      trg_ptr_o <= '0;
      acq_wr_o  <= 1'b0;
      trg_o     <= 1'b0;
    end else begin
      acq_wr_o <= wr_en;
      trg_o    <= fire;
      if (wr_en) begin
        wr_ptr_o <= addr;
        addr     <= addr + AW'(1);
      end
      if (fire) trg_ptr_o <= addr;
      if (cfg_abort_i) begin
        pre_cnt  <= '0;
        post_cnt <= '0;
      end else begin
        if (arm_ok)
          pre_cnt <= '0;
        else if (state == S_PRE && dat_val_i)
          pre_cnt <= pre_cnt + CW'(1);
        if (fire)
          post_cnt <= '0;
        else if (state == S_POST && dat_val_i)
          post_cnt <= post_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rp_acq_ctrl.sv
// tb_rp_acq_ctrl: table vectors, directed corner sequences and
// randomized captures scored against a sample-stream model.
module tb_rp_acq_ctrl;

  localparam int CW = 32;
  localparam int AW = 4;
  localparam int TW = 2;
  localparam int SL = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          abort;
  logic [3:0]    src;
  logic          nw;
  logic [CW-1:0] pre;
  logic [CW-1:0] post;
  logic          val;
  logic          trg;
  logic [TW-1:0] dly;
  logic          acq_wr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trg_ptr;
  logic          trg_o;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  rp_acq_ctrl #(.CW(CW), .AW(AW), .TW(TW)) dut (
    .adc_clk_i(clk),
    .adc_rst_i(rst),
    .cfg_arm_i(arm),
    .cfg_abort_i(abort),
    .cfg_trg_src_i(src),
    .cfg_trg_new_i(nw),
    .cfg_pre_i(pre),
    .cfg_post_i(post),
    .dat_val_i(val),
    .trg_i(trg),
    .dly_sel_o(dly),
    .acq_wr_o(acq_wr),
    .wr_ptr_o(wr_ptr),
    .trg_ptr_o(trg_ptr),
    .trg_o(trg_o),
    .busy_o(busy),
    .done_o(done),
    .state_o(state)
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int err_n = 0;

  logic [AW-1:0] wq[$];
  logic [AW-1:0] tq[$];

  always @(negedge clk) begin
    if (acq_wr) wq.push_back(wr_ptr);
    if (trg_o) tq.push_back(trg_ptr);
  end

  typedef struct {
    logic       arm;
    logic       abort;
    logic       nw;
    logic [3:0] src;
    int         pre;
    int         post;
    logic       val;
    logic       trg;
    int         st;
    int         wr;
    int         tg;
    int         ptr;
    int         tptr;
    int         dly;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    arm = 0; abort = 0; nw = 0; val = 0; trg = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  function automatic int tap_of(input int s, input int cur);
    if ((s >= 2 && s <= 5) || (s >= 10 && s <= 13)) return 1;
    if (s >= 6 && s <= 9) return 2;
    return cur;
  endfunction

  // Capture as a stream of valid samples: pre fill, first triggered
  // sample after the fill, then post samples.
  function automatic void model(input bit v[SL], input bit t[SL],
                                input int p, input int q,
                                output int nwr, output int tix,
                                output bit comp);
    int k;
    int ph;
    int pc;
    k = 0; pc = 0; tix = -1;
    ph = (p == 0) ? 1 : 0;
    for (int i = 0; i < SL; i++) begin
      if (ph == 3) break;
      if (v[i]) begin
        k++;
        if (ph == 0) begin
          if (k == p) ph = 1;
        end else if (ph == 1) begin
          if (t[i]) begin
            tix = k - 1;
            ph = (q == 0) ? 3 : 2;
          end
        end else begin
          pc++;
          if (pc == q) ph = 3;
        end
      end
    end
    nwr = k;
    comp = (ph == 3);
  endfunction

  initial begin
    int p, q, s, nwr, tix, base, mpend;
    bit comp;
    bit vs[SL];
    bit ts[SL];

    pre = 0; post = 0; src = 0;
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_dly", dly, 0);
    chk("rst_wr", acq_wr, 0);
    chk("rst_ptr", wr_ptr, 0);
    chk("rst_tptr", trg_ptr, 0);
    chk("rst_trg", trg_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // arm abort nw src pre post val trg | st wr tg ptr tptr dly
    tbl[0]  = '{0,0,1,4'd3,0,0,0,0, 0,0,0,0,0,0};
    tbl[1]  = '{0,0,0,4'd0,0,0,0,0, 0,0,0,0,0,1};
    tbl[2]  = '{1,0,1,4'd0,0,0,0,0, 2,0,0,0,0,1};
    tbl[3]  = '{0,0,0,4'd0,0,0,0,1, 2,0,0,0,0,1};
    tbl[4]  = '{0,0,0,4'd0,0,0,1,0, 2,1,0,0,0,1};
    tbl[5]  = '{0,0,0,4'd0,0,0,1,1, 4,1,1,1,1,1};
    tbl[6]  = '{0,0,0,4'd0,0,0,1,0, 4,0,0,1,1,1};
    tbl[7]  = '{1,0,1,4'd8,2,1,0,0, 1,0,0,1,1,2};
    tbl[8]  = '{0,0,0,4'd0,2,1,1,1, 1,1,0,2,1,2};
    tbl[9]  = '{0,0,0,4'd0,2,1,1,1, 2,1,0,3,1,2};
    tbl[10] = '{0,0,1,4'd3,2,1,0,0, 2,0,0,3,1,2};
    tbl[11] = '{0,1,0,4'd0,2,1,1,1, 0,0,0,3,1,2};
    tbl[12] = '{0,0,0,4'd0,2,1,0,0, 0,0,0,3,1,1};
    tbl[13] = '{1,1,0,4'd0,2,1,0,0, 0,0,0,3,1,1};
    tbl[14] = '{1,0,1,4'd6,1,2,0,0, 1,0,0,3,1,2};
    tbl[15] = '{0,0,0,4'd0,1,2,1,0, 2,1,0,4,1,2};
    tbl[16] = '{1,0,0,4'd0,1,2,0,0, 2,0,0,4,1,2};
    tbl[17] = '{0,0,0,4'd0,1,2,1,1, 3,1,1,5,5,2};
    tbl[18] = '{0,0,0,4'd0,1,2,1,0, 3,1,0,6,5,2};
    tbl[19] = '{0,0,0,4'd0,1,2,0,0, 3,0,0,6,5,2};
    tbl[20] = '{0,0,0,4'd0,1,2,1,0, 4,1,0,7,5,2};
    tbl[21] = '{0,0,0,4'd0,1,2,0,0, 4,0,0,7,5,2};

    foreach (tbl[i]) begin
      arm = tbl[i].arm; abort = tbl[i].abort; nw = tbl[i].nw;
      src = tbl[i].src; pre = tbl[i].pre; post = tbl[i].post;
      val = tbl[i].val; trg = tbl[i].trg;
      tick();
      chk($sformatf("v%0d_state", i), state, tbl[i].st);
      chk($sformatf("v%0d_wr", i), acq_wr, tbl[i].wr);
      chk($sformatf("v%0d_trg", i), trg_o, tbl[i].tg);
      chk($sformatf("v%0d_ptr", i), wr_ptr, tbl[i].ptr);
      chk($sformatf("v%0d_tptr", i), trg_ptr, tbl[i].tptr);
      chk($sformatf("v%0d_dly", i), dly, tbl[i].dly);
      chk($sformatf("v%0d_busy", i), busy,
          tbl[i].st >= 1 && tbl[i].st <= 3);
      chk($sformatf("v%0d_done", i), done, tbl[i].st == 4);
    end
    idle_in();

    // pre=4 post=3, ten valids with the trigger on the sixth
    do_reset();
    wq.delete(); tq.delete();
    src = 4'd6; nw = 1;
    tick();
    nw = 0; pre = 4; post = 3; arm = 1;
    tick();
    arm = 0;
    chk("s1_dly", dly, 2);
    chk("s1_pre", state, 1);
    for (int i = 0; i < 10; i++) begin
      val = 1; trg = (i == 5);
      tick();
      if (i == 2) chk("s1_still_pre", state, 1);
      if (i == 3) chk("s1_wait", state, 2);
      if (i == 5) chk("s1_trg", trg_o, 1);
    end
    idle_in();
    tick();
    chk("s1_done", done, 1);
    chk("s1_nwr", wq.size(), 9);
    for (int i = 0; i < wq.size() && i < 9; i++)
      chk("s1_addr", wq[i], i);
    chk("s1_ntrg", tq.size(), 1);
    chk("s1_tptr", trg_ptr, 5);

    // 20 writes starting at address 9 cross the 15 -> 0 wrap
    wq.delete(); tq.delete();
    pre = 10; post = 9; arm = 1;
    tick();
    arm = 0;
    chk("wr_pre", state, 1);
    for (int i = 0; i < 20; i++) begin
      val = 1; trg = (i == 10);
      tick();
    end
    idle_in();
    tick();
    chk("wr_done", done, 1);
    chk("wr_nwr", wq.size(), 20);
    for (int i = 0; i < wq.size() && i < 20; i++)
      chk("wr_addr", wq[i], (9 + i) % 16);
    if (wq.size() > 7) begin
      chk("wr_top", wq[6], 15);
      chk("wr_zero", wq[7], 0);
    end
    chk("wr_ntrg", tq.size(), 1);
    chk("wr_tptr", trg_ptr, 3);

    base = 13;
    mpend = 2;
    for (int t = 0; t < 30; t++) begin
      p = $urandom_range(0, 6);
      q = $urandom_range(0, 6);
      s = $urandom_range(0, 15);
      for (int i = 0; i < SL; i++) begin
        vs[i] = ($urandom_range(0, 9) < 6);
        ts[i] = ($urandom_range(0, 9) < 2);
      end
      model(vs, ts, p, q, nwr, tix, comp);
      mpend = tap_of(s, mpend);
      wq.delete(); tq.delete();
      pre = p; post = q; src = 4'(s); nw = 1; arm = 1;
      tick();
      arm = 0; nw = 0;
      chk("rnd_dly", dly, mpend);
      for (int i = 0; i < SL; i++) begin
        val = vs[i]; trg = ts[i];
        tick();
      end
      idle_in();
      tick();
      tick();
      chk("rnd_done", done, comp);
      chk("rnd_nwr", wq.size(), nwr);
      for (int i = 0; i < wq.size() && i < nwr; i++)
        chk("rnd_addr", wq[i], (base + i) % 16);
      chk("rnd_ntrg", tq.size(), tix >= 0);
      if (tix >= 0 && tq.size() > 0)
        chk("rnd_tptr", tq[0], (base + tix) % 16);
      base = (base + nwr) % 16;
      abort = 1;
      tick();
      abort = 0;
      chk("rnd_idle", state, 0);
    end

    // reset while POST is counting
    pre = 0; post = 5; arm = 1;
    tick();
    arm = 0; val = 1; trg = 1;
    tick();
    trg = 0;
    tick();
    chk("rp_post", state, 3);
    rst = 1;
    tick();
    chk("rp_state", state, 0);
    chk("rp_wr", acq_wr, 0);
    chk("rp_ptr", wr_ptr, 0);
    chk("rp_tptr", trg_ptr, 0);
    chk("rp_trg", trg_o, 0);
    chk("rp_busy", busy, 0);
    chk("rp_done", done, 0);
    chk("rp_dly", dly, 0);
    rst = 0;
    tick();
    chk("rp_nowr", acq_wr, 0);
    chk("rp_idle", state, 0);
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
